// File: rtl/pe_ctrl_pkg.sv
// pe_ctrl_pkg: pass-controller state encoding, PE config-word field positions
// and the helper that packs the config word.
package pe_ctrl_pkg;
    typedef enum logic [2:0] {IDLE, CFG, FILTER, IFMAP, IPSUM, OPSUM, DONE} state_t;
    localparam int CFG_W        = 13;
    localparam int CFG_DW_BIT   = 12;
    localparam int CFG_RS_LSB   = 10;
    localparam int CFG_MODE_BIT = 9;
    localparam int CFG_P_LSB    = 7;
    localparam int CFG_F_LSB    = 2;
    localparam int CFG_Q_LSB    = 0;

    function automatic logic [CFG_W-1:0] pack_cfg(
        input logic       dw,
        input logic [1:0] rs_m1,
        input logic       mode,
        input logic [1:0] p_m1,
        input logic [4:0] f_last,
        input logic [1:0] q_m1
    );
        logic [CFG_W-1:0] c;
        c = '0;
        c[CFG_DW_BIT]      = dw;
        c[CFG_RS_LSB +: 2] = rs_m1;
        c[CFG_MODE_BIT]    = mode;
        c[CFG_P_LSB +: 2]  = p_m1;
        c[CFG_F_LSB +: 5]  = f_last;
        c[CFG_Q_LSB +: 2]  = q_m1;
        return c;
    endfunction
endpackage

// File: rtl/pe_feed_skid.sv
// pe_feed_skid: 2-entry FIFO absorbing the one-cycle buffer read latency.
// room already counts the read in flight and the word leaving this cycle.
module pe_feed_skid #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         inflight,
    input  logic [W-1:0] din,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty,
    output logic         room
);
    logic [W-1:0] mem [2];
    logic         wp, rp;
    logic [1:0]   cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wp     <= 1'b0;
            rp     <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (push) begin
                mem[wp] <= din;
                wp      <= ~wp;
            end
            if (pop) rp <= ~rp;
            cnt <= cnt + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head  = mem[rp];
    assign full  = cnt == 2'd2;
    assign empty = cnt == 2'd0;
    assign room  = ({1'b0, cnt} + {2'b0, inflight}) < (3'd2 + {2'b0, pop});
endmodule

// File: rtl/pe_pass_ctrl.sv
// pe_pass_ctrl: runs one PE pass - config pulse, filter/ifmap/ipsum feeds, opsum writeback.
// Defining PE_PASS_CTRL_PERF_EN adds the saturating stall_cnt output.
module pe_pass_ctrl
    import pe_ctrl_pkg::*;
#(
    parameter int DATA_BITS   = 32,
    parameter int CONFIG_SIZE = 13,
    parameter int ADDR_W      = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   cfg_depthwise,
    input  logic [1:0]             cfg_rs_m1,
    input  logic [1:0]             cfg_p_m1,
    input  logic [1:0]             cfg_q_m1,
    input  logic [4:0]             cfg_F,
    input  logic                   cfg_mode,
    input  logic [ADDR_W-1:0]      filt_base,
    input  logic [ADDR_W-1:0]      ifmap_base,
    input  logic [ADDR_W-1:0]      ipsum_base,
    input  logic [ADDR_W-1:0]      opsum_base,
    output logic                   busy,
    output logic                   done,
    output logic                   rd_req,
    output logic [ADDR_W-1:0]      rd_addr,
    input  logic                   rd_gnt,
    input  logic [DATA_BITS-1:0]   rd_data,
    output logic                   wr_en,
    output logic [ADDR_W-1:0]      wr_addr,
    output logic [DATA_BITS-1:0]   wr_data,
    output logic                   pe_en,
    output logic [CONFIG_SIZE-1:0] pe_config,
    output logic [DATA_BITS-1:0]   filter,
    output logic [DATA_BITS-1:0]   ifmap,
    output logic [DATA_BITS-1:0]   ipsum,
    output logic                   filter_valid,
    output logic                   ifmap_valid,
    output logic                   ipsum_valid,
    input  logic                   filter_ready,
    input  logic                   ifmap_ready,
    input  logic                   ipsum_ready,
    input  logic [DATA_BITS-1:0]   opsum,
    input  logic                   opsum_valid,
    output logic                   opsum_ready
`ifdef PE_PASS_CTRL_PERF_EN
    ,
    output logic [31:0]            stall_cnt
`endif
);
    state_t              state, nxt;
    logic                dw, mode, inflight;
    logic [1:0]          rs_m1, p_m1, q_m1;
    logic [4:0]          f_last, col;
    logic [ADDR_W-1:0]   fb, ib, pb, ob, filt_idx, ifm_idx, ips_idx, ops_idx;
    logic [5:0]          iss, xfer, tgt, p6, rs6, ps6;
    logic                strm, s_valid, s_ready, pop, fire, room, full, empty;
    logic [DATA_BITS-1:0] head;

    assign p6      = {4'b0, p_m1} + 6'd1;
    assign rs6     = {4'b0, rs_m1} + 6'd1;
    assign ps6     = dw ? {4'b0, q_m1} + 6'd1 : p6;
    assign tgt     = state == FILTER ? p6 * rs6 :
                     state == IFMAP  ? (col == '0 ? rs6 : 6'd1) : ps6;
    assign strm    = state == FILTER || state == IFMAP || state == IPSUM;
    assign s_ready = state == FILTER ? filter_ready : state == IFMAP ? ifmap_ready : ipsum_ready;
    assign s_valid = strm && !empty;
    assign pop     = s_valid && s_ready;
    assign rd_req  = strm && iss != tgt && room && !full;
    assign fire    = rd_req && rd_gnt;
    assign rd_addr = !rd_req ? '0 :
                     state == FILTER ? fb + filt_idx :
                     state == IFMAP  ? ib + ifm_idx : pb + ips_idx;

    assign busy         = state != IDLE;
    assign done         = state == DONE;
    assign pe_en        = state == CFG;
    assign pe_config    = pe_en ? CONFIG_SIZE'(pack_cfg(dw, rs_m1, mode, p_m1, f_last, q_m1)) : '0;
    assign filter_valid = s_valid && state == FILTER;
    assign ifmap_valid  = s_valid && state == IFMAP;
    assign ipsum_valid  = s_valid && state == IPSUM;
    assign filter       = filter_valid ? head : '0;
    assign ifmap        = ifmap_valid ? head : '0;
    assign ipsum        = ipsum_valid ? head : '0;
    assign opsum_ready  = state == OPSUM && xfer != tgt;
    assign wr_en        = opsum_ready && opsum_valid;
    assign wr_addr      = wr_en ? ob + ops_idx : '0;
    assign wr_data      = wr_en ? opsum : '0;

    pe_feed_skid #(.W(DATA_BITS)) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (inflight),
        .pop      (pop),
        .inflight (inflight),
        .din      (rd_data),
        .head     (head),
        .full     (full),
        .empty    (empty),
        .room     (room)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = start ? CFG : IDLE;
            CFG:     nxt = FILTER;
            FILTER:  nxt = xfer == tgt ? IFMAP : FILTER;
            IFMAP:   nxt = xfer == tgt ? IPSUM : IFMAP;
            IPSUM:   nxt = xfer == tgt ? OPSUM : IPSUM;
            OPSUM:   nxt = xfer != tgt ? OPSUM : col == f_last ? DONE : IFMAP;
            default: nxt = IDLE;
        endcase
    end

    // Stream indices run linearly over the whole pass; only the per-phase counts restart.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {dw, rs_m1, mode, p_m1, f_last, q_m1} <= '0;
            {fb, ib, pb, ob} <= '0;
            {filt_idx, ifm_idx, ips_idx, ops_idx} <= '0;
            {iss, xfer} <= '0;
            col      <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= fire;
            if (state == IDLE && start) begin
                {dw, rs_m1, mode, p_m1, f_last, q_m1} <=
                    {cfg_depthwise, cfg_rs_m1, cfg_mode, cfg_p_m1, cfg_F, cfg_q_m1};
                {fb, ib, pb, ob} <= {filt_base, ifmap_base, ipsum_base, opsum_base};
                {filt_idx, ifm_idx, ips_idx, ops_idx} <= '0;
                col <= '0;
            end
            iss  <= nxt != state ? '0 : iss + 6'(fire);
            xfer <= nxt != state ? '0 : xfer + 6'(pop | wr_en);
            if (fire && state == FILTER) filt_idx <= filt_idx + ADDR_W'(1);
            if (fire && state == IFMAP) ifm_idx <= ifm_idx + ADDR_W'(1);
            if (fire && state == IPSUM) ips_idx <= ips_idx + ADDR_W'(1);
            if (wr_en) ops_idx <= ops_idx + ADDR_W'(1);
            if (state == OPSUM && nxt == IFMAP) col <= col + 5'd1;
        end
    end

`ifdef PE_PASS_CTRL_PERF_EN
    logic stall;
    assign stall = busy && ((rd_req && !rd_gnt) || (s_valid && !s_ready));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cnt <= '0;
        else if (state == IDLE && start) stall_cnt <= '0;
        else if (stall && ~&stall_cnt) stall_cnt <= stall_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_pe_pass_ctrl.sv
// tb_pe_pass_ctrl: table of pass descriptors driven through pe_pass_ctrl against
// a buffer/PE model; expected stream words and writes are queued per pass.
module tb_pe_pass_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0, start = 1'b0;
    logic        cfg_depthwise = 1'b0, cfg_mode = 1'b0;
    logic [1:0]  cfg_rs_m1 = '0, cfg_p_m1 = '0, cfg_q_m1 = '0;
    logic [4:0]  cfg_F = '0;
    logic [15:0] filt_base = '0, ifmap_base = '0, ipsum_base = '0, opsum_base = '0;
    logic        busy, done, rd_req, wr_en, pe_en;
    logic [15:0] rd_addr, wr_addr;
    logic        rd_gnt = 1'b0;
    logic [31:0] rd_data = '0, wr_data, filter, ifmap, ipsum;
    logic [12:0] pe_config;
    logic        filter_valid, ifmap_valid, ipsum_valid, opsum_ready;
    logic        filter_ready = 1'b0, ifmap_ready = 1'b0, ipsum_ready = 1'b0;
    logic [31:0] opsum = '0;
    logic        opsum_valid = 1'b0;
`ifdef PE_PASS_CTRL_PERF_EN
    logic [31:0] stall_cnt;
`endif

    typedef struct {
        logic        dw;
        logic [1:0]  rs_m1, p_m1, q_m1;
        logic [4:0]  f;
        logic        mode;
        logic [15:0] fb, ib, pb, ob;
        int          gmode, rmode;
        bit          dup;
        logic [12:0] exp_cfg;
        int          exp_rd, exp_wr;
    } vec_t;

    vec_t        vt[6];
    vec_t        cur;
    int          checks = 0, errors = 0;
    int          gmode = 0, rmode = 0, stall_left = 0;
    bit          stall_used = 0, tog = 0, pend = 0, prev_wait = 0;
    logic [15:0] pend_addr = '0, prev_addr = '0;
    int          gcnt = 0, xcnt = 0, op_k = 0, pe_cnt = 0, done_cnt = 0;
    logic [31:0] fq[$], iq[$], sq[$];
    logic [47:0] wq[$];

    always #5 clk = ~clk;

    pe_pass_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cfg_depthwise(cfg_depthwise), .cfg_rs_m1(cfg_rs_m1), .cfg_p_m1(cfg_p_m1),
        .cfg_q_m1(cfg_q_m1), .cfg_F(cfg_F), .cfg_mode(cfg_mode),
        .filt_base(filt_base), .ifmap_base(ifmap_base), .ipsum_base(ipsum_base), .opsum_base(opsum_base),
        .busy(busy), .done(done), .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .pe_en(pe_en), .pe_config(pe_config),
        .filter(filter), .ifmap(ifmap), .ipsum(ipsum),
        .filter_valid(filter_valid), .ifmap_valid(ifmap_valid), .ipsum_valid(ipsum_valid),
        .filter_ready(filter_ready), .ifmap_ready(ifmap_ready), .ipsum_ready(ipsum_ready),
        .opsum(opsum), .opsum_valid(opsum_valid), .opsum_ready(opsum_ready)
`ifdef PE_PASS_CTRL_PERF_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    function automatic logic [31:0] mem_f(input logic [15:0] a);
        return {~a, a};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic zero_chk(input string t);
        chk({t, "_ctrl"}, 64'({busy, done, rd_req, wr_en, pe_en, filter_valid, ifmap_valid, ipsum_valid, opsum_ready}), 64'd0);
        chk({t, "_addr"}, 64'({rd_addr, wr_addr}), 64'd0);
        chk({t, "_cfg"}, 64'(pe_config), 64'd0);
        chk({t, "_data"}, 64'(|{wr_data, filter, ifmap, ipsum}), 64'd0);
    endtask

    // Buffer and PE model: inputs change 1 time unit after the rising edge.
    initial forever begin
        @(posedge clk);
        #1;
        rd_data = pend ? mem_f(pend_addr) : '0;
        if (gmode == 1 && gcnt >= 2 && !stall_used) begin
            stall_left = 5;
            stall_used = 1;
        end
        if (gmode == 1 && stall_left > 0) begin
            rd_gnt = 1'b0;
            stall_left--;
        end else rd_gnt = gmode == 2 ? 1'($urandom_range(0, 1)) : 1'b1;
        tog = ~tog;
        filter_ready = rmode == 1 ? tog : rmode == 2 ? 1'($urandom_range(0, 1)) : 1'b1;
        ifmap_ready  = rmode == 2 ? 1'($urandom_range(0, 1)) : 1'b1;
        ipsum_ready  = rmode == 2 ? 1'($urandom_range(0, 1)) : 1'b1;
        opsum_valid  = rmode == 2 ? 1'($urandom_range(0, 1)) : 1'b1;
        opsum        = 32'hC0DE0000 + 32'(op_k);
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            pend = 0;
            prev_wait = 0;
        end else begin
            if (prev_wait) chk("rd_hold", 64'({rd_req, rd_addr}), 64'({1'b1, prev_addr}));
            prev_wait = rd_req && !rd_gnt;
            prev_addr = rd_addr;
            pend = rd_req && rd_gnt;
            pend_addr = rd_addr;
            if (pend) gcnt++;
            if (filter_valid | ifmap_valid | ipsum_valid)
                chk("valid_onehot", 64'($onehot({filter_valid, ifmap_valid, ipsum_valid})), 64'd1);
            if (filter_valid && filter_ready) begin
                xcnt++;
                if (fq.size() == 0) chk("filter_extra", 64'(filter), 64'hDEAD);
                else chk("filter_data", 64'(filter), 64'(fq.pop_front()));
            end
            if (ifmap_valid && ifmap_ready) begin
                xcnt++;
                if (iq.size() == 0) chk("ifmap_extra", 64'(ifmap), 64'hDEAD);
                else chk("ifmap_data", 64'(ifmap), 64'(iq.pop_front()));
            end
            if (ipsum_valid && ipsum_ready) begin
                xcnt++;
                if (sq.size() == 0) chk("ipsum_extra", 64'(ipsum), 64'hDEAD);
                else chk("ipsum_data", 64'(ipsum), 64'(sq.pop_front()));
            end
            if (gcnt != xcnt) chk("skid_occ_le2", 64'((gcnt - xcnt) <= 2), 64'd1);
            if (wr_en) begin
                if (wq.size() == 0) chk("wr_extra", 64'({wr_addr, wr_data}), 64'hDEAD);
                else chk("wr_addr_data", 64'({wr_addr, wr_data}), 64'(wq.pop_front()));
            end
            if (opsum_valid && opsum_ready) op_k++;
            if (pe_en) begin
                pe_cnt++;
                chk("pe_config", 64'(pe_config), 64'(cur.exp_cfg));
            end
            if (done) done_cnt++;
        end
    end

    task automatic load(input vec_t v);
        int p, q, rs, ps, cols;
        cur = v; gmode = v.gmode; rmode = v.rmode; stall_used = 0; stall_left = 0;
        gcnt = 0; xcnt = 0; op_k = 0; pe_cnt = 0; done_cnt = 0;
        p = int'(v.p_m1) + 1; q = int'(v.q_m1) + 1; rs = int'(v.rs_m1) + 1;
        ps = v.dw ? q : p; cols = int'(v.f) + 1;
        for (int i = 0; i < p * rs; i++) fq.push_back(mem_f(16'(v.fb + 16'(i))));
        for (int i = 0; i < rs + cols - 1; i++) iq.push_back(mem_f(16'(v.ib + 16'(i))));
        for (int i = 0; i < ps * cols; i++) sq.push_back(mem_f(16'(v.pb + 16'(i))));
        for (int i = 0; i < ps * cols; i++) wq.push_back({16'(v.ob + 16'(i)), 32'hC0DE0000 + 32'(i)});
        @(posedge clk);
        #2;
        {cfg_depthwise, cfg_rs_m1, cfg_p_m1, cfg_q_m1, cfg_F, cfg_mode} = {v.dw, v.rs_m1, v.p_m1, v.q_m1, v.f, v.mode};
        {filt_base, ifmap_base, ipsum_base, opsum_base} = {v.fb, v.ib, v.pb, v.ob};
        start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
    endtask

    task automatic run(input vec_t v, input string nm);
        int n;
        load(v);
        if (v.dup) begin
            repeat (3) @(posedge clk);
            #2;
            {cfg_depthwise, cfg_rs_m1, cfg_p_m1, cfg_q_m1, cfg_F, cfg_mode} = '1;
            {filt_base, ifmap_base, ipsum_base, opsum_base} = '0;
            start = 1'b1;
            @(posedge clk);
            #2 start = 1'b0;
        end
        n = 0;
        while (done_cnt == 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        chk({nm, "_timeout"}, 64'(n < 3000), 64'd1);
        repeat (3) @(posedge clk);
        #2;
        chk({nm, "_done_pulses"}, 64'(done_cnt), 64'd1);
        chk({nm, "_pe_en_pulses"}, 64'(pe_cnt), 64'd1);
        chk({nm, "_reads"}, 64'(gcnt), 64'(v.exp_rd));
        chk({nm, "_writes"}, 64'(op_k), 64'(v.exp_wr));
        chk({nm, "_left"}, 64'(fq.size() + iq.size() + sq.size() + wq.size()), 64'd0);
        chk({nm, "_idle"}, 64'(busy), 64'd0);
        fq.delete(); iq.delete(); sq.delete(); wq.delete();
    endtask

    initial begin
        int n;
        vt[0] = '{1'b0, 2'd2, 2'd1, 2'd2, 5'd0, 1'b0, 16'h0100, 16'h0200, 16'h0300, 16'h0400, 0, 0, 1'b0, 13'b0_10_0_01_00000_10, 11, 2};
        vt[1] = '{1'b1, 2'd1, 2'd0, 2'd3, 5'd2, 1'b0, 16'h1000, 16'h2000, 16'h3000, 16'h4000, 0, 0, 1'b0, 13'b1_01_0_00_00010_11, 18, 12};
        vt[2] = '{1'b0, 2'd3, 2'd3, 2'd0, 5'd1, 1'b1, 16'h0500, 16'h0600, 16'h0700, 16'h0800, 1, 0, 1'b0, 13'b0_11_1_11_00001_00, 29, 8};
        vt[3] = '{1'b0, 2'd1, 2'd2, 2'd1, 5'd1, 1'b0, 16'h0A00, 16'h0B00, 16'h0C00, 16'h0D00, 0, 1, 1'b0, 13'b0_01_0_10_00001_01, 15, 6};
        vt[4] = '{1'b1, 2'd1, 2'd1, 2'd1, 5'd2, 1'b1, 16'hFFFC, 16'hFFFF, 16'h7000, 16'hFFFE, 0, 0, 1'b1, 13'b1_01_1_01_00010_01, 14, 6};
        vt[5] = '{1'b0, 2'd3, 2'd1, 2'd3, 5'd3, 1'b0, 16'h2200, 16'h3300, 16'h4400, 16'h5500, 2, 2, 1'b0, 13'b0_11_0_01_00011_11, 23, 8};
        repeat (2) @(posedge clk);
        @(negedge clk);
        zero_chk("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        zero_chk("idle");
        for (int i = 0; i < 6; i++) run(vt[i], $sformatf("vec%0d", i));
        load(vt[1]);
        n = 0;
        while (!ipsum_valid && n < 500) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("rst_reach_ipsum", 64'(ipsum_valid), 64'd1);
        #1 rst_n = 1'b0;
        @(negedge clk);
        zero_chk("midrst");
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        zero_chk("postrst");
        fq.delete(); iq.delete(); sq.delete(); wq.delete();
        run(vt[0], "after_rst");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
